// File: rtl/ttx_pkg.sv
// Shared types and helpers for the truth-table extractor: FSM state encoding,
// default input count and the vector-count helper.
package ttx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } ttx_state_t;

    localparam int TTX_N_IN_DEFAULT = 3;

    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/ttx_vec_counter.sv
// Stimulus vector counter: N_IN-bit up-counter with synchronous clear (load to 0),
// count enable and a last-vector flag. Its count is the registered stim bus.
module ttx_vec_counter #(
    parameter int N_IN = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clr,
    input  logic            i_en,
    output logic [N_IN-1:0] o_count,
    output logic            o_last
);

    logic [N_IN-1:0] r_count;

    // Natural N_IN-bit roll-over brings the count back to 0 after the last vector.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + N_IN'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = &r_count;

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps every input vector through two combinational implementations, captures
// both minterm masks and reports equivalence. Optional TTX_MISMATCH_COUNT_EN adds a mismatch counter.
module truth_table_extractor
    import ttx_pkg::*;
#(
    parameter  int N_IN  = TTX_N_IN_DEFAULT,
    localparam int N_VEC = vec_count(N_IN)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic [N_IN-1:0]  o_stim,
    input  logic             i_f_a,
    input  logic             i_f_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [N_VEC-1:0] o_minterms_a,
    output logic [N_VEC-1:0] o_minterms_b,
    output logic             o_equal,
    output logic [N_IN-1:0]  o_first_mismatch
`ifdef TTX_MISMATCH_COUNT_EN
    ,
    output logic [N_IN:0]    o_mismatch_count
`endif
);

    ttx_state_t r_state;
    ttx_state_t w_state_nxt;

    logic            w_clr;
    logic            w_en;
    logic            w_last;
    logic [N_IN-1:0] w_stim;
    logic            w_mis;

    logic [N_VEC-1:0] r_min_a;
    logic [N_VEC-1:0] r_min_b;
    logic             r_equal;
    logic [N_IN-1:0]  r_first_mis;
    logic             r_mis_found;

    ttx_vec_counter #(
        .N_IN (N_IN)
    ) u_vec_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_count (w_stim),
        .o_last  (w_last)
    );

    assign w_mis = i_f_a ^ i_f_b;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = SWEEP;
                    w_clr       = 1'b1;
                end
            end
            SWEEP: begin
                w_en = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // equal folds in the last vector's mismatch, since the flag updates on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_min_a     <= '0;
            r_min_b     <= '0;
            r_equal     <= 1'b0;
            r_first_mis <= '0;
            r_mis_found <= 1'b0;
        end else if (r_state == IDLE && i_start) begin
            r_min_a     <= '0;
            r_min_b     <= '0;
            r_equal     <= 1'b0;
            r_first_mis <= '0;
            r_mis_found <= 1'b0;
        end else if (r_state == SWEEP) begin
            r_min_a[w_stim] <= i_f_a;
            r_min_b[w_stim] <= i_f_b;
            if (w_mis && !r_mis_found) begin
                r_first_mis <= w_stim;
                r_mis_found <= 1'b1;
            end
            if (w_last) begin
                r_equal <= ~(r_mis_found | w_mis);
            end
        end
    end

`ifdef TTX_MISMATCH_COUNT_EN
    logic [N_IN:0] r_mis_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mis_cnt <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_mis_cnt <= '0;
        end else if (r_state == SWEEP && w_mis) begin
            r_mis_cnt <= r_mis_cnt + (N_IN + 1)'(1);
        end
    end

    assign o_mismatch_count = r_mis_cnt;
`endif

    assign o_stim           = w_stim;
    assign o_busy           = (r_state == SWEEP);
    assign o_done           = (r_state == DONE);
    assign o_minterms_a     = r_min_a;
    assign o_minterms_b     = r_min_b;
    assign o_equal          = r_equal;
    assign o_first_mismatch = r_first_mis;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Self-checking bench for truth_table_extractor: truth-table model plus directed sweeps.
// Honours TTX_MISMATCH_COUNT_EN when the design is built with it.
module tb_truth_table_extractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] stim;
    logic       f_a;
    logic       f_b;
    logic       busy;
    logic       done;
    logic [7:0] min_a;
    logic [7:0] min_b;
    logic       equal;
    logic [2:0] first_mis;
`ifdef TTX_MISMATCH_COUNT_EN
    logic [3:0] mis_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;

    truth_table_extractor #(.N_IN(3)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .o_stim           (stim),
        .i_f_a            (f_a),
        .i_f_b            (f_b),
        .o_busy           (busy),
        .o_done           (done),
        .o_minterms_a     (min_a),
        .o_minterms_b     (min_b),
        .o_equal          (equal),
        .o_first_mismatch (first_mis)
`ifdef TTX_MISMATCH_COUNT_EN
        ,
        .o_mismatch_count (mis_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Functions under test: original expression and its simplified form
    function automatic logic fn_orig(input logic [2:0] s);
        logic a, b, c;
        a = s[2]; b = s[1]; c = s[0];
        return (~a & ~c) | (a & b & c) | (a & ~c);
    endfunction

    function automatic logic fn_simp(input logic [2:0] s);
        return ~s[0] | (s[2] & s[1] & s[0]);
    endfunction

    function automatic logic fn_b(input int md, input logic [2:0] s);
        case (md)
            0:       return fn_simp(s);
            1:       return 1'b0;
            default: return fn_orig(s) ^ (s == 3'd5);
        endcase
    endfunction

    always_comb begin
        f_a = fn_orig(stim);
        f_b = fn_b(mode, stim);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected results straight from the truth tables
    task automatic compute(input int md, output logic [7:0] ma, output logic [7:0] mb,
                           output logic eq, output logic [2:0] fm, output logic [3:0] cnt);
        logic found;
        logic [2:0] s;
        found = 1'b0; fm = 3'd0; cnt = 4'd0; ma = 8'h00; mb = 8'h00;
        for (int i = 0; i < 8; i++) begin
            s = 3'(i);
            ma[i] = fn_orig(s);
            mb[i] = fn_b(md, s);
            if (ma[i] != mb[i]) begin
                cnt = cnt + 4'd1;
                if (!found) begin
                    found = 1'b1;
                    fm = s;
                end
            end
        end
        eq = (ma == mb);
    endtask

    // Model: m_t = cycles since accepted start (-1 idle, 0..7 sweep, 8 done cycle)
    int         m_t = -1;
    bit         armed = 0;
    logic [7:0] h_ma, h_mb, p_ma, p_mb;
    logic       h_eq, p_eq;
    logic [2:0] h_fm, p_fm;
    logic [3:0] h_cnt, p_cnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_t = -1; armed = 1;
            h_ma = 0; h_mb = 0; h_eq = 0; h_fm = 0; h_cnt = 0;
        end else if (m_t == -1) begin
            if (start) begin
                m_t = 0;
                h_ma = 0; h_mb = 0; h_eq = 0; h_fm = 0; h_cnt = 0;
                compute(mode, p_ma, p_mb, p_eq, p_fm, p_cnt);
            end
        end else if (m_t < 7) begin
            m_t++;
        end else if (m_t == 7) begin
            m_t = 8;
            h_ma = p_ma; h_mb = p_mb; h_eq = p_eq; h_fm = p_fm; h_cnt = p_cnt;
        end else begin
            m_t = -1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", busy, (m_t >= 0 && m_t <= 7));
            chk("done", done, (m_t == 8));
            chk("stim", stim, (m_t >= 0 && m_t <= 7) ? 3'(m_t) : 3'd0);
            if (m_t <= 0 || m_t == 8) begin
                chk("minterms_a", min_a, h_ma);
                chk("minterms_b", min_b, h_mb);
                chk("equal", equal, h_eq);
                chk("first_mismatch", first_mis, h_fm);
`ifdef TTX_MISMATCH_COUNT_EN
                chk("mismatch_count", mis_cnt, h_cnt);
`endif
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Leaves the caller at the negedge inside the done cycle
    task automatic wait_done();
        int c;
        c = 0;
        while (!done && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk("done_timeout", done, 1'b1);
    endtask

    task automatic lit(input logic [7:0] ma, input logic [7:0] mb, input logic eq,
                       input logic [2:0] fm, input logic [3:0] cnt);
        chk("lit_minterms_a", min_a, ma);
        chk("lit_minterms_b", min_b, mb);
        chk("lit_equal", equal, eq);
        chk("lit_first_mismatch", first_mis, fm);
`ifdef TTX_MISMATCH_COUNT_EN
        chk("lit_mismatch_count", mis_cnt, cnt);
`else
        if (cnt > 4'd8) chk("lit_cnt_range", cnt, 4'd0);
`endif
    endtask

    int  n_done, n_busy, c;
    bit  seen;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (2) @(negedge clk);
        chk("rst_stim", stim, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        lit(8'h00, 8'h00, 1'b0, 3'd0, 4'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Equivalent implementations
        mode = 0;
        pulse_start();
        wait_done();
        lit(8'hD5, 8'hD5, 1'b1, 3'd0, 4'd0);

        // f_b tied low
        @(negedge clk);
        mode = 1;
        pulse_start();
        wait_done();
        lit(8'hD5, 8'h00, 1'b0, 3'd0, 4'd5);

        // Single-minterm difference at 5
        @(negedge clk);
        mode = 2;
        pulse_start();
        wait_done();
        lit(8'hD5, 8'hF5, 1'b0, 3'd5, 4'd1);

        // Back-to-back: start in the first IDLE cycle after done
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_cleared_a", min_a, 8'h00);
        chk("b2b_cleared_b", min_b, 8'h00);
        wait_done();
        lit(8'hD5, 8'hD5, 1'b1, 3'd0, 4'd0);

        // start held through sweep and the done cycle
        @(negedge clk);
        mode = 2;
        start = 1'b1;
        n_done = 0; n_busy = 0; seen = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (seen) start = 1'b0;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                seen = 1;
            end
        end
        start = 1'b0;
        chk("hold_done_pulses", n_done, 1);
        chk("hold_busy_cycles", n_busy, 8);
        lit(8'hD5, 8'hF5, 1'b0, 3'd5, 4'd1);

        // Reset at sweep vector 3
        mode = 0;
        pulse_start();
        c = 0;
        while (!(busy && stim == 3'd3) && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("reach_vec3", stim, 3'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_stim", stim, 3'd0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        lit(8'h00, 8'h00, 1'b0, 3'd0, 4'd0);
        pulse_start();
        wait_done();
        lit(8'hD5, 8'hD5, 1'b1, 3'd0, 4'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_extractor.md
Name: truth_table_extractor

Overview:
- Sequential sweep engine that is the inverse of a gate-level expression block: it reads a combinational Boolean function back into a minterm mask.
- It drives every input combination onto a stimulus bus and captures one or two function outputs per vector.
- It reports both minterm masks and whether the two implementations are equivalent.
- Intended use: on-chip equivalence check of an original expression against its simplified form.

Parameters:
- N_IN, 3, number of function inputs; stim[N_IN-1] is the MSB (A), stim[0] is the LSB (C).
- N_VEC, 2**N_IN, derived; number of vectors and the minterm mask width. Do not override.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- stim  out  N_IN  registered vector driven to the function(s) under test.
- f_a  in  1  output of implementation A for the current stim.
- f_b  in  1  output of implementation B for the current stim.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse when results become valid.
- minterms_a  out  N_VEC  bit i = f_a captured with stim==i.
- minterms_b  out  N_VEC  bit i = f_b captured with stim==i.
- equal  out  1  1 iff minterms_a == minterms_b; valid from done.
- first_mismatch  out  N_IN  lowest i where the masks differ; 0 when equal==1.

Behaviour:
- Reset: with rst_n low at a clock edge, state=IDLE and every output is 0: stim, busy, done, minterms_a, minterms_b, equal, first_mismatch.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - start=1: go to SWEEP; stim<=0; clear minterms_a/b, equal and first_mismatch; internal mismatch-found flag <=0.
  - start=0: hold all results.
- SWEEP:
  - busy=1.
  - Each edge captures f_a into minterms_a[stim] and f_b into minterms_b[stim], then increments stim.
  - One vector per cycle. The function under test is purely combinational and sees registered stim for a full cycle.
  - First mismatch: if f_a!=f_b and the mismatch-found flag is 0, set first_mismatch<=stim and set the flag.
  - Last vector (stim==N_VEC-1): capture, then go to DONE. stim wraps to 0 (N_IN-bit roll-over, no extra logic).
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - equal = ~flag, registered on entry to DONE.
  - Unconditionally return to IDLE. start in the DONE cycle is ignored.
- Latency: start sampled at edge 0; done high during the cycle following edge N_VEC (edge 8 for N_IN=3); busy high for N_VEC cycles.
- start while busy or in DONE: ignored; no restart, no error.
- Results hold from done until the next accepted start.
- Reset mid-sweep: immediate return to IDLE with all outputs cleared; partial masks are discarded.
- No X-propagation handling: X on f_a/f_b is captured as-is.

Optional Feature:
- Macro: TTX_MISMATCH_COUNT_EN
- Defined:
  - Adds output mismatch_count, width N_IN+1.
  - Cleared on reset and on accepted start.
  - Increments once per SWEEP cycle with f_a!=f_b; saturation is impossible since the width covers N_VEC.
  - Valid from done.
- Undefined: port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Package ttx_pkg:
  - State enum ttx_state_t {IDLE, SWEEP, DONE}.
  - Default N_IN constant.
  - Function vec_count(n) returning 2**n.
- Sub-module ttx_vec_counter: N_IN-bit loadable up-counter with clear, enable and last-vector flag (last = &count). It drives stim.
- FSM and capture registers live in the top.

Test Plan:
- Original-form expression on f_a (~A&~C | A&B&C | A&~C) and simplified form (~C | A&B&C) on f_b, start pulse -> done in the cycle after edge 8; minterms_a=minterms_b=8'hD5; equal=1; first_mismatch=0; mismatch_count=0.
- f_b tied 0, f_a=original expression -> minterms_b=8'h00; equal=0; first_mismatch=0; mismatch_count=5.
- f_b = f_a ^ (stim==5) -> minterms_b=8'hF5; equal=0; first_mismatch=5; mismatch_count=1.
- start re-asserted every cycle during SWEEP and in the DONE cycle -> exactly one done pulse; stim sequence 0..7 once; busy high 8 cycles.
- rst_n low for one edge at sweep vector 3 -> all outputs 0, state IDLE; a new start then yields a clean 8'hD5 result.
- Back-to-back: start in the first IDLE cycle after done -> new sweep; previous results cleared on accept.
